// File: rtl/memc_pkg.sv
// Shared types and default sizing for the memc_drain de-skew buffer.
package memc_pkg;

  localparam int BITS_C_DEF = 24;
  localparam int DIM_DEF    = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2
  } state_e;

endpackage

// File: rtl/memc_drain_skew_pipe.sv
// Delay chain that tracks which buffer row each lane is currently carrying.
// Lane 0 is the accepted strobe itself; lane k is that strobe delayed k cycles.
module skew_pipe
  import memc_pkg::*;
#(
  parameter int DIM = DIM_DEF,
  parameter int RW  = $clog2(DIM_DEF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [RW-1:0] in_row,
  output logic          lane_valid [DIM],
  output logic [RW-1:0] lane_row   [DIM]
);

  logic          valid_q [DIM-1];
  logic          valid_d [DIM-1];
  logic [RW-1:0] row_q   [DIM-1];
  logic [RW-1:0] row_d   [DIM-1];

  always_comb begin
    valid_d[0] = in_valid;
    row_d[0]   = in_row;
    for (int k = 1; k < DIM - 1; k++) begin
      valid_d[k] = valid_q[k-1];
      row_d[k]   = row_q[k-1];
    end
  end

  always_comb begin
    lane_valid[0] = in_valid;
    lane_row[0]   = in_row;
    for (int k = 1; k < DIM; k++) begin
      lane_valid[k] = valid_q[k-1];
      lane_row[k]   = row_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DIM - 1; k++) begin
        valid_q[k] <= 1'b0;
        row_q[k]   <= '0;
      end
    end else begin
      valid_q <= valid_d;
      row_q   <= row_d;
    end
  end

endmodule

// File: rtl/memc_drain.sv
// Collects skewed systolic-array column outputs into a row buffer and drains
// de-skewed rows over a valid/ready handshake. Define MEMC_DRAIN_ERR_EN for a sticky err output.
module memc_drain
  import memc_pkg::*;
#(
  parameter int BITS_C = BITS_C_DEF,
  parameter int DIM    = DIM_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       cin_valid,
  input  logic signed [BITS_C-1:0]   Cin [DIM],
  output logic                       Cout_valid,
  input  logic                       Cout_ready,
  output logic signed [BITS_C-1:0]   Cout [DIM],
  output logic [$clog2(DIM)-1:0]     Cout_row,
  output logic                       busy,
  output logic                       done
`ifdef MEMC_DRAIN_ERR_EN
  ,
  output logic                       err
`endif
);

  localparam int RW = $clog2(DIM);
  localparam int CW = RW + 1;

  state_e                     state_q, state_d;
  logic [CW-1:0]              wr_cnt_q, wr_cnt_d;
  logic [RW-1:0]              rd_ptr_q, rd_ptr_d;
  logic                       done_q, done_d;
  logic signed [BITS_C-1:0]   row_buf_q [DIM][DIM];
  logic signed [BITS_C-1:0]   row_buf_d [DIM][DIM];

  logic                       cin_acc;
  logic                       start_acc;
  logic                       hs;
  logic                       last_hs;
  logic                       last_capture;
  logic                       lane_valid [DIM];
  logic [RW-1:0]              lane_row   [DIM];

  skew_pipe #(.DIM(DIM), .RW(RW)) u_skew (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (cin_acc),
    .in_row     (wr_cnt_q[RW-1:0]),
    .lane_valid (lane_valid),
    .lane_row   (lane_row)
  );

  always_comb begin
    cin_acc      = (state_q == ST_COLLECT) && cin_valid && (wr_cnt_q < CW'(DIM));
    start_acc    = (state_q == ST_IDLE) && start;
    hs           = (state_q == ST_DRAIN) && Cout_ready;
    last_hs      = hs && (rd_ptr_q == RW'(DIM - 1));
    last_capture = lane_valid[DIM-1] && (lane_row[DIM-1] == RW'(DIM - 1));
  end

  // The tile is complete once the final row's last lane lands in the buffer.
  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_ptr_d = rd_ptr_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_acc) begin
          state_d  = ST_COLLECT;
          wr_cnt_d = '0;
          rd_ptr_d = '0;
        end
      end
      ST_COLLECT: begin
        if (cin_acc) wr_cnt_d = wr_cnt_q + CW'(1);
        if (last_capture) begin
          state_d  = ST_DRAIN;
          rd_ptr_d = '0;
        end
      end
      ST_DRAIN: begin
        if (last_hs) begin
          state_d  = ST_IDLE;
          rd_ptr_d = '0;
          done_d   = 1'b1;
        end else if (hs) begin
          rd_ptr_d = rd_ptr_q + RW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    row_buf_d = row_buf_q;
    for (int j = 0; j < DIM; j++) begin
      if (lane_valid[j]) row_buf_d[lane_row[j]][j] = Cin[j];
    end
  end

  always_comb begin
    for (int j = 0; j < DIM; j++) begin
      Cout[j] = (state_q == ST_DRAIN) ? row_buf_q[rd_ptr_q][j] : row_buf_q[0][j];
    end
    Cout_row   = (state_q == ST_DRAIN) ? rd_ptr_q : '0;
    Cout_valid = (state_q == ST_DRAIN);
    busy       = (state_q != ST_IDLE);
    done       = done_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wr_cnt_q <= '0;
      rd_ptr_q <= '0;
      done_q   <= 1'b0;
      for (int r = 0; r < DIM; r++) begin
        for (int j = 0; j < DIM; j++) begin
          row_buf_q[r][j] <= '0;
        end
      end
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_ptr_q  <= rd_ptr_d;
      done_q    <= done_d;
      row_buf_q <= row_buf_d;
    end
  end

`ifdef MEMC_DRAIN_ERR_EN
  logic err_q, err_d;

  // An accepted start clears the flag, but a violation in that same cycle still sets it.
  always_comb begin
    err_d = (err_q && !start_acc)
          || (cin_valid && !cin_acc)
          || (start && (state_q != ST_IDLE));
    err   = err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
`endif

endmodule

// File: tb/tb_memc_drain.sv
// Self-checking bench for memc_drain: drives skewed rows (lane j of row r = 100*r + j)
// and checks de-skewed drain order, timing, stalls, ignored strobes and mid-tile reset.
module tb_memc_drain;

  localparam int DIM  = 8;
  localparam int BITS = 24;

  logic                     clk = 1'b0;
  logic                     rst, start, cin_valid, Cout_ready;
  logic                     Cout_valid, busy, done;
  logic signed [BITS-1:0]   Cin  [DIM];
  logic signed [BITS-1:0]   Cout [DIM];
  logic [2:0]               Cout_row;
`ifdef MEMC_DRAIN_ERR_EN
  logic                     err;
`endif

  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   n_issued = 0;
  int   issue_cyc [DIM];
  logic collecting = 1'b0;

  memc_drain #(.BITS_C(BITS), .DIM(DIM)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cin_valid  (cin_valid),
    .Cin        (Cin),
    .Cout_valid (Cout_valid),
    .Cout_ready (Cout_ready),
    .Cout       (Cout),
    .Cout_row   (Cout_row),
    .busy       (busy),
`ifdef MEMC_DRAIN_ERR_EN
    .err        (err),
`endif
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  // Lane j carries row r exactly j cycles after row r's strobe; other lanes get junk.
  task automatic drive_cin();
    for (int j = 0; j < DIM; j++) begin
      Cin[j] = BITS'($urandom);
      for (int r = 0; r < n_issued; r++) begin
        if (issue_cyc[r] + j == cyc) Cin[j] = BITS'(100 * r + j);
      end
    end
  endtask

  task automatic tick();
    drive_cin();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic pulse_cin();
    cin_valid = 1'b1;
    if (collecting && n_issued < DIM) begin
      issue_cyc[n_issued] = cyc;
      n_issued++;
    end
    tick();
    cin_valid = 1'b0;
  endtask

  task automatic start_tile();
    start      = 1'b1;
    Cout_ready = 1'($urandom);
    tick();
    start      = 1'b0;
    collecting = 1'b1;
    n_issued   = 0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL start_busy actual=%b required=1", busy);
    end
  endtask

  // gap_mode: 0 back-to-back, 2 every third cycle, -1 random 0..3 idle cycles.
  task automatic collect(int gap_mode, bit extra_pulse);
    int t_exp;
    for (int r = 0; r < DIM; r++) begin
      pulse_cin();
      if (r < DIM - 1) begin
        int gaps;
        gaps = (gap_mode < 0) ? int'($urandom_range(0, 3)) : gap_mode;
        for (int g = 0; g < gaps; g++) begin
          Cout_ready = 1'($urandom);
          tick();
        end
      end
    end
    if (extra_pulse) pulse_cin();
    t_exp = issue_cyc[DIM-1] + DIM;
    while (cyc < t_exp) begin
      n_cmp++;
      if (Cout_valid !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL early_valid cyc=%0d actual=%b required=0", cyc, Cout_valid);
      end
      Cout_ready = 1'($urandom);
      tick();
    end
    collecting = 1'b0;
    n_cmp++;
    if (Cout_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL valid_latency actual=%b/%b required=1/1", Cout_valid, busy);
    end
  endtask

  // stall_row >= 0 holds ready low stall_len cycles at that row; -2 gives random ready.
  task automatic drain(int stall_row, int stall_len, bit inject);
    int row = 0;
    int stalled = 0;
    int guard = 0;
    bit ready;
    bit first = 1'b1;
    while (row < DIM && guard < 200) begin
      bit ok = 1'b1;
      int bad = 0;
      n_cmp++;
      if (Cout_valid !== 1'b1 || Cout_row !== 3'(row)) begin
        n_fail++;
        $display("[TB] FAIL drain_row actual=%b/%0d required=1/%0d", Cout_valid, Cout_row, row);
      end
      for (int j = 0; j < DIM; j++) begin
        if (Cout[j] !== BITS'(100 * row + j)) begin
          ok = 1'b0;
          bad = j;
        end
      end
      n_cmp++;
      if (!ok) begin
        n_fail++;
        $display("[TB] FAIL row_data row=%0d lane=%0d actual=%0d required=%0d",
                 row, bad, Cout[bad], 100 * row + bad);
      end
      if (stall_row == -2) ready = 1'($urandom);
      else ready = !(row == stall_row && stalled < stall_len);
      if (inject && first) ready = 1'b0;
      if (!ready) stalled++;
      Cout_ready = ready;
      if (inject) begin
        start     = first ? 1'b1 : 1'($urandom);
        cin_valid = 1'($urandom);
      end
      first = 1'b0;
      tick();
      start     = 1'b0;
      cin_valid = 1'b0;
      if (ready) row++;
      guard++;
    end
    n_cmp++;
    if (guard >= 200) begin
      n_fail++;
      $display("[TB] FAIL drain_budget actual=%0d required=<200", guard);
    end
    Cout_ready = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || Cout_valid !== 1'b0 || busy !== 1'b0 || Cout_row !== 3'd0) begin
      n_fail++;
      $display("[TB] FAIL done_pulse actual=done%b valid%b busy%b row%0d required=done1 valid0 busy0 row0",
               done, Cout_valid, busy, Cout_row);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL done_single actual=%b required=0", done);
    end
  endtask

  task automatic check_idle_zero(string name);
    bit ok = 1'b1;
    for (int j = 0; j < DIM; j++) if (Cout[j] !== '0) ok = 1'b0;
    n_cmp++;
    if (!ok || Cout_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || Cout_row !== 3'd0) begin
      n_fail++;
      $display("[TB] FAIL %s actual=valid%b busy%b done%b row%0d lane0=%0d required=all zero",
               name, Cout_valid, busy, done, Cout_row, Cout[0]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; cin_valid = 1'b0; Cout_ready = 1'b0;
    tick();
    tick();
    check_idle_zero("reset_state");
    rst = 1'b0;
    Cout_ready = 1'b1;
    cin_valid  = 1'b1;
    tick();
    cin_valid  = 1'b0;
    check_idle_zero("idle_ignores_inputs");
  endtask

  task automatic test_back_to_back();
    start_tile();
    collect(0, 1'b0);
    n_cmp++;
    if (Cout_row !== 3'd0 || Cout[3] !== BITS'(3)) begin
      n_fail++;
      $display("[TB] FAIL first_row actual=%0d/%0d required=0/3", Cout_row, Cout[3]);
    end
    drain(-1, 0, 1'b0);
  endtask

  task automatic test_gapped();
    start_tile();
    collect(2, 1'b0);
    drain(-1, 0, 1'b0);
  endtask

  task automatic test_stall();
    start_tile();
    collect(0, 1'b0);
    drain(2, 4, 1'b0);
  endtask

  task automatic test_protocol();
    start_tile();
    collect(0, 1'b1);
`ifdef MEMC_DRAIN_ERR_EN
    n_cmp++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL err_set actual=%b required=1", err);
    end
`endif
    drain(-1, 0, 1'b1);
`ifdef MEMC_DRAIN_ERR_EN
    start_tile();
    n_cmp++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL err_clear actual=%b required=0", err);
    end
    collect(0, 1'b0);
    drain(-1, 0, 1'b0);
`endif
  endtask

  task automatic test_reset_mid();
    start_tile();
    for (int r = 0; r < 4; r++) pulse_cin();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    collecting = 1'b0;
    n_issued   = 0;
    check_idle_zero("mid_reset");
    for (int k = 0; k < 4; k++) begin
      tick();
      check_idle_zero("reset_discard_inflight");
    end
    start_tile();
    collect(0, 1'b0);
    drain(-1, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 4; t++) begin
      start_tile();
      collect(-1, 1'b0);
      drain(-2, 0, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cin_valid = 1'b0; Cout_ready = 1'b0;
    for (int j = 0; j < DIM; j++) Cin[j] = '0;
    test_reset();
    test_back_to_back();
    test_gapped();
    test_stall();
    test_protocol();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
